dram64_bist_ctrl: RTL and testbench
===================================

Name: dram64_bist_ctrl

Overview:
- Built-in self-test sequencer for a pair of 64x1 dual-port distributed RAMs (RAM64X1D, one per lane).
- Upstream side: drives the shared write/SPO address bus, the dual-port read address (DPRA), per-lane data and WE.
- Downstream side: consumes SPO/DPO from both RAMs, checks them against an expected pattern, and reports pass/fail status for LEDs or a debug bus.
- Sits between board-level start/status I/O and the two RAM primitives in the xc7 DRAM test designs.

Parameters:
- ADDR_W, 6, RAM address width; depth is 2**ADDR_W.
- LANES, 2, number of 1-bit RAMs under test; all lanes share the address buses.
- CNT_W, 8, error counter width; only used when DRAM_BIST_ERRCNT_EN is defined.

Ports:
- clk  input  1  single system clock; drives RAM WCLK.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled only in IDLE or DONE.
- ram_a  output  ADDR_W  to RAM A5..A0 (write and SPO address).
- ram_dpra  output  ADDR_W  to RAM DPRA5..DPRA0.
- ram_d  output  LANES  per-lane write data.
- ram_we  output  1  shared write enable.
- ram_spo  input  LANES  SPO from each RAM (asynchronous read).
- ram_dpo  input  LANES  DPO from each RAM (asynchronous read).
- busy  output  1  high from the start-accept edge until DONE.
- done  output  1  high in DONE.
- pass  output  1  valid while done=1; 1 means no mismatch.
- fail_addr  output  ADDR_W  address of the first mismatch.
- fail_lane  output  clog2(LANES) (min 1)  lane of the first mismatch.
- fail_port  output  1  port of the first mismatch: 0=SPO, 1=DPO.
- err_count  output  CNT_W  total mismatches, saturating.

Behaviour:
- Reset values (all asynchronous): state=IDLE, address counter=0, ram_we=0, ram_d=0, ram_a=0, ram_dpra=0, busy=0, done=0, pass=0, fail_*=0, err_count=0.
- Expected bit for lane l at address a in pass p (p=0 normal, p=1 inverted): exp = (^a) ^ l[0] ^ p.
- States: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> DONE.
- Start accept: start=1 sampled in IDLE or DONE clears pass/fail_*/err_count/done, sets busy=1, counter=0, and enters WR0. Call this edge 0.
- WRx (64 cycles): ram_we=1, ram_a=counter, ram_d[l]=exp. Counter increments each cycle and wraps 63->0, then goes to RDx.
- RDx (65 cycles): ram_we=0, ram_a=ram_dpra=counter.
  - SPO and DPO are read combinationally in the same cycle; compare results are registered one cycle later, so the 65th cycle only flushes the last compare.
- Mismatch check: any mismatch on any lane or port increments err_count.
  - The first mismatch of a run latches fail_addr/fail_lane/fail_port. Priority: lowest lane, then SPO before DPO.
  - The test continues after a mismatch; it is never aborted.
- Timing: DONE is entered at edge 258, so done=1 and busy=0 from edge 258.
  - pass = (no mismatch seen during the run).
  - ram_we=0 in IDLE and DONE.
- start held high in DONE starts a new run at the next edge. start during busy is ignored.
- rst mid-run: ram_we drops immediately (asynchronously); RAM contents are undefined and the bench must not rely on them.
- Address outputs are registered. No combinational path from ram_spo/ram_dpo to any output.

Optional Feature:
- DRAM_BIST_ERRCNT_EN defined: err_count is a CNT_W saturating counter of every mismatch (all lanes and ports, both read passes); it holds at 2**CNT_W-1.
- Not defined: err_count is tied to 0 and no counter logic is generated; pass/fail_* behaviour is unchanged.

Test Plan:
- Clean RAM model, start pulse at edge 0 -> busy for 258 cycles; done=1 and pass=1 at edge 258; err_count=0; exactly 128 cycles with ram_we=1.
- Lane 1 DPO forced stuck-at-0 at address 17 -> pass=0, fail_addr=17, fail_lane=1, fail_port=1, err_count=1. The address-17 lane-1 expected value is 1 in exactly one of the two passes.
- Lane 0 stuck-at-1 on both ports at all addresses -> first failure at fail_addr=0 (exp=0 in pass 0), fail_lane=0, fail_port=0; err_count=128 with the macro defined, 0 without it.
- start pulsed at edge 100 during a run -> ignored; done still rises at edge 258.
- rst asserted at edge 70 -> ram_we, busy and all status outputs are 0 immediately. A new start after release completes a full 258-cycle pass=1 run.
- start held high continuously -> a new run begins the edge after DONE is entered; done pulses for one cycle between runs and status clears on restart.

Source files
------------

// File: rtl/dram64_bist_ctrl.sv
// dram64_bist_ctrl: BIST sequencer for LANES x (2**ADDR_W)x1 dual-port distributed RAMs.
// Ports: clk/rst (async, active-high); start (level, sampled in IDLE/DONE);
//   ram_a/ram_dpra/ram_d/ram_we drive the RAMs; ram_spo/ram_dpo are the async read data;
//   busy/done/pass/fail_addr/fail_lane/fail_port/err_count report status.
// Optional: define DRAM_BIST_ERRCNT_EN to build the saturating mismatch counter (else err_count=0).
module dram64_bist_ctrl #(
  parameter int ADDR_W = 6,
  parameter int LANES  = 2,
  parameter int CNT_W  = 8,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_a,
  output logic [ADDR_W-1:0] ram_dpra,
  output logic [LANES-1:0]  ram_d,
  output logic              ram_we,
  input  logic [LANES-1:0]  ram_spo,
  input  logic [LANES-1:0]  ram_dpo,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [LW-1:0]     fail_lane,
  output logic              fail_port,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

  state_t state, state_nxt;
  // One extra MSB so a read pass can run one cycle past the last address to
  // flush the registered compare of address 2**ADDR_W-1.
  logic [ADDR_W:0] cnt, cnt_nxt;

  logic is_wr, is_rd, phase, start_acc, last_wr, last_rd;
  logic [LANES-1:0] exp_vec;

  assign is_wr     = (state == WR0) || (state == WR1);
  assign is_rd     = (state == RD0) || (state == RD1);
  assign phase     = (state == WR1) || (state == RD1);
  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign last_wr   = (cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});
  assign last_rd   = cnt[ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: if (start) begin state_nxt = WR0; cnt_nxt = '0; end
      WR0: if (last_wr) begin state_nxt = RD0; cnt_nxt = '0; end
           else cnt_nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
      RD0: if (last_rd) begin state_nxt = WR1; cnt_nxt = '0; end
           else cnt_nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
      WR1: if (last_wr) begin state_nxt = RD1; cnt_nxt = '0; end
           else cnt_nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
      RD1: if (last_rd) begin state_nxt = DONE; cnt_nxt = '0; end
           else cnt_nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
      default: begin state_nxt = IDLE; cnt_nxt = '0; end
    endcase
  end

  // Checkerboard-by-parity pattern, offset per lane, inverted in the second pass.
  always_comb begin
    exp_vec = '0;
    for (int l = 0; l < LANES; l++)
      exp_vec[l] = (^cnt[ADDR_W-1:0]) ^ l[0] ^ phase;
  end

  assign ram_we   = is_wr;
  assign ram_a    = cnt[ADDR_W-1:0];
  assign ram_dpra = cnt[ADDR_W-1:0];
  assign ram_d    = is_wr ? exp_vec : '0;
  assign busy     = is_wr || is_rd;
  assign done     = (state == DONE);

  // Compare stage: RAM read data is registered as mismatch vectors so no
  // combinational path exists from the RAM outputs to any port.
  logic              cmp_vld;
  logic [LANES-1:0]  cmp_spo, cmp_dpo;
  logic [ADDR_W-1:0] cmp_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_vld  <= 1'b0;
      cmp_spo  <= '0;
      cmp_dpo  <= '0;
      cmp_addr <= '0;
    end else begin
      cmp_vld  <= is_rd && !last_rd;
      cmp_spo  <= ram_spo ^ exp_vec;
      cmp_dpo  <= ram_dpo ^ exp_vec;
      cmp_addr <= cnt[ADDR_W-1:0];
    end
  end

  logic          cmp_any, sel_found, sel_port, err_seen;
  logic [LW-1:0] sel_lane;

  assign cmp_any = cmp_vld && ((|cmp_spo) || (|cmp_dpo));

  // Lowest lane wins; within a lane SPO wins over DPO.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    sel_port  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (!sel_found && cmp_spo[l]) begin
        sel_found = 1'b1; sel_lane = LW'(l); sel_port = 1'b0;
      end else if (!sel_found && cmp_dpo[l]) begin
        sel_found = 1'b1; sel_lane = LW'(l); sel_port = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_seen  <= 1'b0;
      fail_addr <= '0;
      fail_lane <= '0;
      fail_port <= 1'b0;
    end else if (start_acc) begin
      err_seen  <= 1'b0;
      fail_addr <= '0;
      fail_lane <= '0;
      fail_port <= 1'b0;
    end else if (cmp_any) begin
      err_seen <= 1'b1;
      if (!err_seen) begin
        fail_addr <= cmp_addr;
        fail_lane <= sel_lane;
        fail_port <= sel_port;
      end
    end
  end

  assign pass = done && !err_seen;

`ifdef DRAM_BIST_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic [7:0]       mis_n;
  logic [CNT_W+7:0] err_sum;

  always_comb begin
    mis_n = '0;
    for (int l = 0; l < LANES; l++)
      mis_n = mis_n + 8'(cmp_spo[l]) + 8'(cmp_dpo[l]);
    err_sum = {8'b0, err_cnt_q} + {{CNT_W{1'b0}}, mis_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt_q <= '0;
    else if (start_acc)
      err_cnt_q <= '0;
    else if (cmp_vld)
      err_cnt_q <= (err_sum > {8'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_dram64_bist_ctrl.sv
// tb_dram64_bist_ctrl: directed bench with a behavioural RAM pair, fault injection
// and a cycle-indexed model of the expected sequencer outputs.
module tb_dram64_bist_ctrl;
  localparam int AW = 6;
  localparam int LN = 2;
  localparam int CW = 8;
`ifdef DRAM_BIST_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] ram_a, ram_dpra, fail_addr;
  logic [LN-1:0] ram_d, ram_spo, ram_dpo;
  logic ram_we, busy, done, pass, fail_port;
  logic [0:0] fail_lane;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  dram64_bist_ctrl #(.ADDR_W(AW), .LANES(LN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_a(ram_a), .ram_dpra(ram_dpra), .ram_d(ram_d), .ram_we(ram_we),
    .ram_spo(ram_spo), .ram_dpo(ram_dpo),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_lane(fail_lane), .fail_port(fail_port),
    .err_count(err_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fault modes: 0 clean, 1 lane1 DPO stuck-0 at addr 17,
  // 2 lane0 stuck-1 on both ports, 3 every read inverted.
  int fault = 0;

  function automatic logic ram_out(int f, int l, int port, int a, logic stored);
    case (f)
      1: if (l == 1 && port == 1 && a == 17) return 1'b0;
      2: if (l == 0) return 1'b1;
      3: return ~stored;
      default: ;
    endcase
    return stored;
  endfunction

  function automatic logic exp_bit(int a, int l, int p);
    logic [5:0] av;
    av = a[5:0];
    return (^av) ^ l[0] ^ p[0];
  endfunction

  logic mem [LN][64];

  always @(posedge clk)
    if (ram_we)
      for (int l = 0; l < LN; l++) mem[l][ram_a] <= ram_d[l];

  always_comb begin
    for (int l = 0; l < LN; l++) begin
      ram_spo[l] = ram_out(fault, l, 0, int'(ram_a),    mem[l][ram_a]);
      ram_dpo[l] = ram_out(fault, l, 1, int'(ram_dpra), mem[l][ram_dpra]);
    end
  end

  // Expected run outcome from the fault description: walk reads in time order
  // (pass, address), then lane, then SPO before DPO.
  task automatic model_expect(input int f, output logic ps, output int fa,
                              output int fl, output int fp, output int cnt);
    logic e, g;
    ps = 1'b1; fa = 0; fl = 0; fp = 0; cnt = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 64; a++)
        for (int l = 0; l < LN; l++)
          for (int port = 0; port < 2; port++) begin
            e = exp_bit(a, l, p);
            g = ram_out(f, l, port, a, e);
            if (g !== e) begin
              if (ps) begin fa = a; fl = l; fp = port; end
              ps = 1'b0;
              cnt++;
            end
          end
    if (cnt > 255) cnt = 255;
    if (!ERRCNT) cnt = 0;
  endtask

  // mk = cycles since the accepted start edge; -1 idle after reset, 258 = done.
  int mk = -1;
  logic e_pass;
  int e_fa, e_fl, e_fp, e_cnt;
  int we_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) mk = -1;
    else if ((mk == -1 || mk == 258) && start) begin
      mk = 0;
      model_expect(fault, e_pass, e_fa, e_fl, e_fp, e_cnt);
    end else if (mk >= 0 && mk < 258) mk++;
  end

  always @(negedge clk) begin
    logic [LN-1:0] ed;
    int a, p;
    if (rst || mk == -1) begin
      chk("idle_we", ram_we, 0);   chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);   chk("idle_pass", pass, 0);
      chk("idle_err", err_count, 0); chk("idle_faddr", fail_addr, 0);
      chk("idle_flane", fail_lane, 0); chk("idle_fport", fail_port, 0);
      chk("idle_a", ram_a, 0);     chk("idle_d", ram_d, 0);
    end else if (mk < 258) begin
      if (mk == 0) we_cnt = 0;
      if (ram_we) we_cnt++;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_we", ram_we, ((mk < 64) || (mk >= 129 && mk < 193)) ? 1 : 0);
      if (mk < 64 || (mk >= 129 && mk < 193)) begin
        a = (mk < 64) ? mk : mk - 129;
        p = (mk < 64) ? 0 : 1;
        for (int l = 0; l < LN; l++) ed[l] = exp_bit(a, l, p);
        chk("wr_addr", ram_a, a);
        chk("wr_data", ram_d, ed);
      end else if ((mk >= 64 && mk < 128) || (mk >= 193 && mk < 257)) begin
        a = (mk < 128) ? mk - 64 : mk - 193;
        chk("rd_a", ram_a, a);
        chk("rd_dpra", ram_dpra, a);
      end
      if (mk <= 64) begin
        chk("clr_err", err_count, 0);
        chk("clr_faddr", fail_addr, 0);
        chk("clr_flane", fail_lane, 0);
        chk("clr_fport", fail_port, 0);
      end
    end else begin
      chk("end_busy", busy, 0);
      chk("end_done", done, 1);
      chk("end_we", ram_we, 0);
      chk("end_we_cycles", we_cnt, 128);
      chk("end_pass", pass, e_pass);
      chk("end_err", err_count, e_cnt);
      chk("end_faddr", fail_addr, e_fa);
      chk("end_flane", fail_lane, e_fl);
      chk("end_fport", fail_port, e_fp);
    end
  end

  task automatic wait_mk(input int target, input int budget);
    int n = 0;
    while (mk != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mk != target) begin
      failures++;
      $display("FAIL wait_mk: got mk=%0d expected %0d", mk, target);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fault = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run.
    pulse_start();
    wait_mk(258, 300);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);

    // Single DPO fault on lane 1, address 17 (mismatch only in pass 0).
    fault = 1;
    pulse_start();
    wait_mk(258, 300);
    chk("t2_pass", pass, 0);
    chk("t2_faddr", fail_addr, 17);
    chk("t2_flane", fail_lane, 1);
    chk("t2_fport", fail_port, 1);
    chk("t2_err", err_count, ERRCNT ? 1 : 0);

    // Lane 0 stuck-at-1 on both ports.
    fault = 2;
    pulse_start();
    wait_mk(258, 300);
    chk("t3_pass", pass, 0);
    chk("t3_faddr", fail_addr, 0);
    chk("t3_flane", fail_lane, 0);
    chk("t3_fport", fail_port, 0);
    chk("t3_err", err_count, ERRCNT ? 128 : 0);

    // Every read wrong: 512 mismatches, counter saturates.
    fault = 3;
    pulse_start();
    wait_mk(258, 300);
    chk("t3b_pass", pass, 0);
    chk("t3b_err", err_count, ERRCNT ? 255 : 0);

    // start during a run is ignored.
    fault = 0;
    pulse_start();
    wait_mk(99, 120);
    pulse_start();
    wait_mk(258, 300);
    chk("t4_pass", pass, 1);

    // Reset mid-run.
    fault = 2;
    pulse_start();
    wait_mk(70, 100);
    #1 rst = 1'b1;
    #1;
    chk("t5_we", ram_we, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_pass", pass, 0);
    chk("t5_err", err_count, 0);
    chk("t5_faddr", fail_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    fault = 0;
    pulse_start();
    wait_mk(258, 300);
    chk("t5_rerun_pass", pass, 1);

    // start held high: back-to-back runs, status cleared on restart.
    fault = 1;
    @(negedge clk) start = 1'b1;
    wait_mk(0, 5);
    wait_mk(258, 300);
    chk("t6_first_pass", pass, 0);
    fault = 0;
    wait_mk(0, 5);
    wait_mk(258, 300);
    start = 1'b0;
    chk("t6_second_pass", pass, 1);
    chk("t6_second_faddr", fail_addr, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
